// File: rtl/cla_serial_adder.sv
// cla_serial_adder: WIDTH-bit adder that runs a 4-bit carry-lookahead stage one
// nibble per cycle, LSB nibble first, with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is 1 only while idle
//   a, b, cin           operands and carry into bit 0, captured on accept
//   out_valid/out_ready result handshake; result held until out_ready
//   sum, cout, ovf      a+b+cin mod 2^WIDTH, carry out, signed overflow
//   blk_g, blk_p        whole-word group generate / propagate (cin-independent)
module cla_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             blk_g,
   output logic             blk_p
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            in_ready_nx;
   logic            out_valid_nx;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [KW-1:0]    k;
   logic             acc_g;
   logic             acc_p;

   logic             last;
   logic [3:0]       g;
   logic [3:0]       p;
   logic             c0, c1, c2, c3, c4;
   logic             gn, pn;
   logic [3:0]       s_nib;
   logic             acc_g_nx;
   logic             acc_p_nx;

   assign last = (k == KW'(N - 1));

   // Lookahead stage on the current nibble; operands shift right each step,
   // so the active nibble is always in bits [3:0].
   assign g  = a_q[3:0] & b_q[3:0];
   assign p  = a_q[3:0] ^ b_q[3:0];
   assign c0 = carry_q;
   assign c1 = g[0] | (p[0] & c0);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign c4 = g[3] | (p[3] & c3);
   assign gn = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pn = &p;
   assign s_nib    = p ^ {c3, c2, c1, c0};
   assign acc_g_nx = gn | (pn & acc_g);
   assign acc_p_nx = acc_p & pn;

   // State register, also holding the registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from the upcoming state
   always_comb begin
      in_ready_nx  = 1'b0;
      out_valid_nx = 1'b0;
      if (state_nx == IDLE) in_ready_nx  = 1'b1;
      if (state_nx == DONE) out_valid_nx = 1'b1;
   end

   // Operand capture and per-nibble datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k       <= '0;
         acc_g   <= 1'b0;
         acc_p   <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         blk_g   <= 1'b0;
         blk_p   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         k       <= '0;
         acc_g   <= 1'b0;
         acc_p   <= 1'b1;
      end else if (state == RUN) begin
         a_q     <= a_q >> 4;
         b_q     <= b_q >> 4;
         carry_q <= c4;
         k       <= k + KW'(1);
         acc_g   <= acc_g_nx;
         acc_p   <= acc_p_nx;
         for (int unsigned j = 0; j < N; j++) begin
            if (k == KW'(j)) sum[4*j +: 4] <= s_nib;
         end
         if (last) begin
            cout  <= c4;
            ovf   <= c3 ^ c4;
            blk_g <= acc_g_nx;
            blk_p <= acc_p_nx;
         end
      end
   end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: directed vectors, stall, mid-run reset, random
// operations and continuous back-to-back traffic against an arithmetic model.
module tb_cla_serial_adder;

   localparam int unsigned W  = 16;
   localparam int unsigned W1 = W + 1;
   localparam int unsigned N  = W / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         blk_g;
   logic         blk_p;

   int total = 0;
   int bad   = 0;

   cla_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .blk_g     (blk_g),
      .blk_p     (blk_p)
   );

   always #5 clk = ~clk;

   // Reference: {sum, cout, ovf, blk_g, blk_p} from plain integer arithmetic
   function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      logic [W:0] t;
      logic [W:0] u;
      logic       ov;
      t  = {1'b0, x} + {1'b0, y} + W1'(ci);
      u  = {1'b0, x} + {1'b0, y};
      ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return {t[W-1:0], t[W], ov, u[W], &(x ^ y)};
   endfunction

   function automatic logic [W+3:0] outs();
      return {sum, cout, ovf, blk_g, blk_p};
   endfunction

   // Present operands for one cycle, then scramble them to prove capture
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      @(negedge clk);
      in_valid = 1'b1; a = av; b = bv; cin = cv;
      @(negedge clk);
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      total++;
      if (outs() !== '0) begin bad++; $display("FAIL reset_outputs got %h want 0", outs()); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic         vc [4];
      logic [W+3:0] ve [4];
      int           lat;
      va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0; ve[0] = {16'h5555, 4'b0000};
      va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0; ve[1] = {16'h0000, 4'b1010};
      va[2] = 16'h7FFF; vb[2] = 16'h0001; vc[2] = 1'b0; ve[2] = {16'h8000, 4'b0100};
      va[3] = 16'hFFFF; vb[3] = 16'h0000; vc[3] = 1'b1; ve[3] = {16'h0000, 4'b1001};
      for (int i = 0; i < 4; i++) begin
         start_op(va[i], vb[i], vc[i]);
         wait_done(lat);
         total++;
         if (lat != N) begin bad++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, N); end
         total++;
         if (outs() !== ve[i]) begin
            bad++; $display("FAIL directed%0d_result got %h want %h", i, outs(), ve[i]);
         end
         consume();
      end
   endtask

   task automatic test_stall();
      int           lat;
      logic [W+3:0] exp_o;
      exp_o = {16'h5555, 4'b0000};
      start_op(16'h1234, 16'h4321, 1'b0);
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || outs() !== exp_o) begin
            bad++;
            $display("FAIL stall%0d got ov=%b ir=%b o=%h want ov=1 ir=0 o=%h",
                     i, out_valid, in_ready, outs(), exp_o);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL stall_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
      total++;
      if (outs() !== exp_o) begin bad++; $display("FAIL stall_hold_idle got %h want %h", outs(), exp_o); end
   endtask

   task automatic test_midrun_reset();
      int lat;
      int seen;
      start_op(16'hAAAA, 16'h5555, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL midrst_state got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
      total++;
      if (sum !== '0) begin bad++; $display("FAIL midrst_sum got %h want 0", sum); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
      start_op(16'h0003, 16'h0004, 1'b0);
      wait_done(lat);
      total++;
      if (lat != N) begin bad++; $display("FAIL midrst_latency got %0d want %0d", lat, N); end
      total++;
      if (sum !== 16'h0007) begin bad++; $display("FAIL midrst_sum7 got %h want 0007", sum); end
      consume();
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      logic         ci;
      logic [W+3:0] exp_o;
      int           lat;
      for (int i = 0; i < 40; i++) begin
         x  = W'($urandom);
         y  = W'($urandom);
         ci = 1'($urandom);
         case ($urandom_range(0, 4))
            0: x = '1;
            1: y = ~x;
            2: begin x = '1; y = '0; end
            default: ;
         endcase
         exp_o = model(x, y, ci);
         start_op(x, y, ci);
         wait_done(lat);
         total++;
         if (lat != N) begin bad++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, N); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         total++;
         if (outs() !== exp_o) begin
            bad++; $display("FAIL rand%0d a=%h b=%h cin=%b got %h want %h", i, x, y, ci, outs(), exp_o);
         end
         consume();
      end
   endtask

   task automatic test_back_to_back();
      logic [W+3:0] q[$];
      logic [W+3:0] exp_o;
      int           nv;
      nv = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (out_valid === 1'b1) begin
            nv++;
            total++;
            if (in_ready === 1'b1) begin bad++; $display("FAIL b2b%0d_both_ready got ir=1 ov=1 want exclusive", i); end
            exp_o = (q.size() > 0) ? q.pop_front() : '0;
            total++;
            if (outs() !== exp_o) begin bad++; $display("FAIL b2b%0d_result got %h want %h", i, outs(), exp_o); end
         end
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if (in_ready === 1'b1) q.push_back(model(a, b, cin));
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++;
      if (nv != 10 || q.size() != 0) begin
         bad++; $display("FAIL b2b_count got results=%0d pending=%0d want 10 and 0", nv, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_midrun_reset();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
